// File: rtl/fetch_stage_ctrl.sv
// Program counter and IF/ID pipeline register with redirect, stall and sticky halt handling.
// Optional build macro FETCH_ALIGN_CHECK_EN forces redirect targets to word alignment and flags misaligned ones.
module fetch_stage_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic [31:0] Instruction,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        Stall,
    input  logic        Halt,
    output logic [31:0] PCResult,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [1:0]  FetchState,
    output logic        MisalignErr
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'b00,
        ST_STALLED = 2'b01,
        ST_HALTED  = 2'b10
    } fetch_state_t;

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  ifid_instr_q, ifid_instr_d;
    logic [31:0]  ifid_pc4_q, ifid_pc4_d;
    logic         ifid_valid_q, ifid_valid_d;
    logic         redirect;
    logic [31:0]  redirect_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic         misalign_q, misalign_d;
`endif

    assign redirect        = Jump | BranchTaken;
    assign redirect_target = Jump ? JumpTarget : BranchTarget;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
`ifdef FETCH_ALIGN_CHECK_EN
        misalign_d   = misalign_q;
`endif
        case (state_q)
            ST_HALTED: state_d = ST_HALTED;
            ST_FETCH, ST_STALLED: begin
                if (Halt) begin
                    state_d = ST_HALTED;
                end else if (redirect) begin
                    // Redirect squashes whatever sits in IF/ID, even under a stall.
                    state_d      = ST_FETCH;
                    ifid_instr_d = NOP_WORD;
                    ifid_pc4_d   = 32'h0;
                    ifid_valid_d = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
                    pc_d = redirect_target & ~32'h3;
                    if (redirect_target[1:0] != 2'b00) begin
                        misalign_d = 1'b1;
                    end
`else
                    pc_d = redirect_target;
`endif
                end else if (Stall) begin
                    state_d = ST_STALLED;
                end else begin
                    state_d      = ST_FETCH;
                    pc_d         = PCAddResult;
                    ifid_instr_d = Instruction;
                    ifid_pc4_d   = PCAddResult;
                    ifid_valid_d = 1'b1;
                end
            end
            default: state_d = Halt ? ST_HALTED : ST_FETCH;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_VECTOR;
            ifid_instr_q <= NOP_WORD;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q   <= misalign_d;
`endif
        end
    end

    assign PCResult         = pc_q;
    assign IFID_Instruction = ifid_instr_q;
    assign IFID_PCPlus4     = ifid_pc4_q;
    assign IFID_Valid       = ifid_valid_q;
    assign FetchState       = state_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign MisalignErr      = misalign_q;
`else
    assign MisalignErr      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Scoreboard bench for fetch_stage_ctrl: directed scenarios then randomized traffic against a reference model.
module tb_fetch_stage_ctrl;

    localparam logic [31:0] RV  = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [31:0] PCAddResult;
    logic [31:0] Instruction;
    logic        BranchTaken = 1'b0;
    logic [31:0] BranchTarget = 32'h0;
    logic        Jump = 1'b0;
    logic [31:0] JumpTarget = 32'h0;
    logic        Stall = 1'b0;
    logic        Halt = 1'b0;
    logic [31:0] PCResult;
    logic [31:0] IFID_Instruction;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic [1:0]  FetchState;
    logic        MisalignErr;

    fetch_stage_ctrl #(.RESET_VECTOR(RV), .NOP_WORD(NOP)) dut (
        .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult), .Instruction(Instruction),
        .BranchTaken(BranchTaken), .BranchTarget(BranchTarget), .Jump(Jump),
        .JumpTarget(JumpTarget), .Stall(Stall), .Halt(Halt), .PCResult(PCResult),
        .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid(IFID_Valid), .FetchState(FetchState), .MisalignErr(MisalignErr)
    );

    always #5 Clk = ~Clk;

    // Environment: PC adder and an instruction memory whose contents are a function of the address.
    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a ^ 32'h5A5A_1234) + {a[15:0], 16'h0};
    endfunction
    assign PCAddResult = PCResult + 32'd4;
    assign Instruction = imem(PCResult);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        val;
        logic [1:0]  st;
        logic        mis;
    } obs_t;

    obs_t exp_q[$];
    obs_t m;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: the architectural effect of one clock edge given the inputs in force.
    task automatic step(input bit rst, input bit hlt, input bit jmp, input logic [31:0] jt,
                        input bit brt, input logic [31:0] bt, input bit stl);
        logic [31:0] tgt;
        Reset = rst; Halt = hlt; Jump = jmp; JumpTarget = jt;
        BranchTaken = brt; BranchTarget = bt; Stall = stl;
        if (rst) begin
            m = '{pc: RV, ins: NOP, p4: 32'h0, val: 1'b0, st: 2'b00, mis: 1'b0};
        end else if (hlt || m.st == 2'b10) begin
            m.st = 2'b10;
        end else if (jmp || brt) begin
            tgt = jmp ? jt : bt;
`ifdef FETCH_ALIGN_CHECK_EN
            if (tgt % 4 != 0) m.mis = 1'b1;
            tgt = tgt - (tgt % 4);
`endif
            m.pc = tgt; m.ins = NOP; m.p4 = 32'h0; m.val = 1'b0; m.st = 2'b00;
        end else if (stl) begin
            m.st = 2'b01;
        end else begin
            m.ins = imem(m.pc);
            m.p4  = m.pc + 32'd4;
            m.pc  = m.p4;
            m.val = 1'b1;
            m.st  = 2'b00;
        end
        exp_q.push_back(m);
        @(negedge Clk);
    endtask

    task automatic free_run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    // Monitor: each edge the DUT presents new registered outputs; compare them with the oldest expectation.
    always @(posedge Clk) begin
        obs_t got, want;
        #1;
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            got  = '{pc: PCResult, ins: IFID_Instruction, p4: IFID_PCPlus4,
                     val: IFID_Valid, st: FetchState, mis: MisalignErr};
            n_cmp++;
            if (got !== want) begin
                n_bad++;
                $display("FAIL edge_%0d: got pc=%h ins=%h p4=%h v=%b st=%b mis=%b required pc=%h ins=%h p4=%h v=%b st=%b mis=%b",
                         n_cmp, got.pc, got.ins, got.p4, got.val, got.st, got.mis,
                         want.pc, want.ins, want.p4, want.val, want.st, want.mis);
            end
        end
    end

    initial begin
        m = '0;
        @(negedge Clk);
        step(1, 0, 0, 32'h0, 0, 32'h0, 0);
        free_run(4);                                    // 4, 8, 12, 0x10
        step(0, 0, 0, 32'h0, 0, 32'h0, 1);
        step(0, 0, 0, 32'h0, 0, 32'h0, 1);
        free_run(1);                                    // 0x14
        step(0, 0, 0, 32'h0, 1, 32'h40, 1);             // branch beats stall
        free_run(2);
        step(0, 0, 1, 32'h100, 1, 32'h40, 0);           // jump beats branch
        free_run(2);
        step(0, 1, 0, 32'h0, 0, 32'h0, 0);
        step(0, 0, 1, 32'h200, 0, 32'h0, 0);            // ignored while halted
        step(0, 0, 0, 32'h0, 1, 32'h300, 1);
        step(1, 1, 0, 32'h0, 0, 32'h0, 0);              // reset wins over halt
        step(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 0);
        free_run(2);                                    // wraps to 0
        step(0, 0, 1, 32'h102, 0, 32'h0, 0);
        free_run(2);
        step(0, 0, 0, 32'h0, 1, 32'h81, 0);
        free_run(1);
        step(1, 0, 0, 32'h0, 0, 32'h0, 0);
        free_run(1);

        for (int i = 0; i < 400; i++) begin
            bit rst, hlt, jmp, brt, stl;
            logic [31:0] jt, bt;
            rst = ($urandom_range(99) < 3);
            hlt = ($urandom_range(99) < 3);
            jmp = ($urandom_range(99) < 8);
            brt = ($urandom_range(99) < 12);
            stl = ($urandom_range(99) < 25);
            jt  = {$urandom_range(32'h3FF), 2'b00};
            bt  = {$urandom_range(32'h3FF), 2'b00};
            if ($urandom_range(9) == 0) jt[1:0] = 2'($urandom_range(3));
            if ($urandom_range(9) == 0) bt[1:0] = 2'($urandom_range(3));
            step(rst, hlt, jmp, jt, brt, bt, stl);
        end

        Reset = 0; Halt = 0; Jump = 0; BranchTaken = 0; Stall = 0;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
